spi_cmd_engine: RTL
===================

Name: spi_cmd_engine

Overview:
- Byte-level command decoder that sits directly downstream of the SPI slave and also feeds its TX side.
- Consumes received bytes (RX_DV/RX_Byte) and decodes opcode/address/data frames.
- Issues single 32-bit read/write transfers on a req/ack register-bus master port.
- Returns read data and status by pushing bytes back to the slave's TX_DV/TX_Byte.

Parameters:
- ADDR_W, 32, bus address width; multiple of 8; sent MSB-byte first.
- DATA_W, 32, bus data width; multiple of 8; sent MSB-byte first.
- BUS_TIMEOUT, 1023, i_Clk cycles to wait for i_Bus_Ack before aborting with error.
- IDLE_BYTE, 8'hA5, byte pushed to TX when there is nothing to return.

Ports:
- i_Clk  in  1  system clock (same clock as the SPI slave).
- i_Rst  in  1  asynchronous active-high reset.
- i_RX_DV  in  1  one-cycle pulse: i_RX_Byte valid (from slave o_RX_DV).
- i_RX_Byte  in  8  received byte.
- i_TX_Ready  in  1  slave holds a loaded TX byte not yet shifted out.
- o_TX_DV  out  1  one-cycle pulse: load o_TX_Byte into the slave.
- o_TX_Byte  out  8  byte to be shifted out on MISO.
- i_SPI_CS_n  in  1  raw chip select, asynchronous to i_Clk.
- o_Bus_Req  out  1  transfer request; held until ack.
- o_Bus_We  out  1  1 = write, 0 = read; stable while req is high.
- o_Bus_Addr  out  ADDR_W  transfer address.
- o_Bus_WData  out  DATA_W  write data.
- i_Bus_Ack  in  1  one-cycle completion pulse.
- i_Bus_RData  in  DATA_W  read data; valid with ack.
- o_Status  out  8  {5'b0, ovf, timeout_err, last_ok}; sticky bits.

Behaviour:
- Reset: all outputs 0 except o_TX_Byte = IDLE_BYTE; FSM = IDLE; byte counter 0.
- CS handling:
  - i_SPI_CS_n passes through a 2-flop synchronizer.
  - A synchronized high forces the FSM to IDLE on the next cycle, unless a bus transfer is outstanding. In that case the FSM goes to ABORT, waits for ack or timeout, discards the result, then goes to IDLE.
- Opcodes, taken from the first byte after CS falls:
  - 0x02 WRITE: then ADDR_W/8 address bytes, then DATA_W/8 data bytes.
  - 0x03 READ: then ADDR_W/8 address bytes, one turnaround byte, then DATA_W/8 read-data bytes.
  - 0x05 STATUS: the next byte returns o_Status. Reading status clears ovf and timeout_err.
  - Any other opcode: go to DRAIN.
- States:
  - IDLE: on RX_DV, decode the opcode.
  - ADDR: count address bytes.
  - WDATA: count data bytes.
  - BUS: req high until ack or timeout.
  - TURN: waiting on the turnaround byte.
  - RDATA: return read-data bytes.
  - DRAIN: ignore bytes until CS rises.
  - ABORT: see CS handling.
- Write path:
  - On the RX_DV of the last data byte, assert o_Bus_Req/o_Bus_We=1 in the next cycle.
  - On ack: set last_ok=1, go to DRAIN.
  - On timeout: drop req, set timeout_err, last_ok=0, go to DRAIN.
- Read path:
  - On the RX_DV of the last address byte, assert req with We=0 in the next cycle.
  - On ack, latch RData into the shift register.
  - On the RX_DV of the turnaround byte:
    - If data is latched, push byte [DATA_W-1 -: 8].
    - Otherwise push 8'hEE, set timeout_err, go to DRAIN.
  - Each following RX_DV in RDATA pushes the next lower byte.
  - After the last data byte has been pushed, subsequent pushes send IDLE_BYTE.
- TX push rule:
  - o_TX_DV pulses exactly one cycle, 1 cycle after the triggering i_RX_DV.
  - A push is only legal while i_TX_Ready=0.
  - If i_TX_Ready=1 at push time, the byte is dropped and ovf is set. The slave keeps its previous byte.
- Bytes received in BUS/ABORT are discarded and set ovf; the state is unchanged.
- Timeout counter: ceil(log2(BUS_TIMEOUT+1)) bits. It counts only while req is high, clears on ack or on entering BUS, and at BUS_TIMEOUT a timeout fires.
- Ack and timeout in the same cycle: ack wins.
- Reset mid-transfer: req drops immediately; no state survives.

Decomposition:
- Shared package spi_cmd_pkg holds:
  - opcode constants OP_WRITE=8'h02, OP_READ=8'h03, OP_STATUS=8'h05;
  - the FSM state enum;
  - the STATUS bit indices;
  - the 8'hEE not-ready code.
- Sub-module spi_cs_sync: 2-flop synchronizer plus rising/falling-edge detect for i_SPI_CS_n.

Test Plan:
- WRITE: CS low; bytes 02 00 00 10 04 DE AD BE EF -> one req with We=1, Addr=0x00001004, WData=0xDEADBEEF; ack after 3 cycles -> o_Status=0x01.
- READ: bytes 03 00 00 00 20, dummy, then 4 dummies; bus acks in 5 cycles with RData=0x12345678 -> TX pushes 12, 34, 56, 78, then A5.
- READ slow bus: ack arrives after the turnaround RX_DV -> TX pushes EE; timeout_err=1; the late ack is discarded.
- Timeout: write with no ack -> req drops after exactly 1023 cycles; o_Status=0x02; the following STATUS frame (05, dummy) returns 0x02, then o_Status=0x00.
- CS abort: raise CS after 2 address bytes -> no req, FSM in IDLE; next frame 03 decodes correctly. Raise CS while req is pending -> ABORT, the ack is swallowed, no TX push.
- Overflow and bad opcode: i_TX_Ready held 1 during a READ return -> no o_TX_DV, ovf=1. Opcode 0x7F -> no bus activity until CS high.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared opcodes, FSM states and status layout
// for the SPI command engine.
package spi_cmd_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h05;

  localparam logic [7:0] NOT_READY = 8'hEE;

  localparam int ST_OK  = 0;
  localparam int ST_TMO = 1;
  localparam int ST_OVF = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_TURN  = 3'd4,
    S_RDATA = 3'd5,
    S_DRAIN = 3'd6,
    S_ABORT = 3'd7
  } state_e;

endpackage

// File: rtl/spi_cs_sync.sv
// spi_cs_sync: 2-flop synchronizer for the raw chip select,
// plus rising/falling edge pulses of the synchronized level.
module spi_cs_sync (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_CS_n,
  output logic o_CS_n,
  output logic o_Rise,
  output logic o_Fall
);

  logic [2:0] sync_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], i_CS_n};
  end

  assign o_CS_n = sync_q[1];
  assign o_Rise = sync_q[1] & ~sync_q[2];
  assign o_Fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_cmd_engine.sv
// spi_cmd_engine: decodes SPI byte frames into single register-bus
// read/write transfers and returns read data/status on the TX side.
module spi_cmd_engine
  import spi_cmd_pkg::*;
#(
  parameter int         ADDR_W      = 32,
  parameter int         DATA_W      = 32,
  parameter int         BUS_TIMEOUT = 1023,
  parameter logic [7:0] IDLE_BYTE   = 8'hA5
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  input  logic              i_TX_Ready,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  input  logic              i_SPI_CS_n,
  output logic              o_Bus_Req,
  output logic              o_Bus_We,
  output logic [ADDR_W-1:0] o_Bus_Addr,
  output logic [DATA_W-1:0] o_Bus_WData,
  input  logic              i_Bus_Ack,
  input  logic [DATA_W-1:0] i_Bus_RData,
  output logic [7:0]        o_Status
);

  localparam int ADDR_B = ADDR_W / 8;
  localparam int DATA_B = DATA_W / 8;
  localparam int TW     = $clog2(BUS_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUS_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              rdv_q, rdv_d;
  logic              req_q, req_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              ok_q, ok_d;
  logic              terr_q, terr_d;
  logic              ovf_q, ovf_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;

  logic       cs_s, cs_rise, cs_fall;
  logic       push, st_rd, fire, done;
  logic [7:0] push_byte;

  spi_cs_sync u_cs_sync (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_CS_n (i_SPI_CS_n),
    .o_CS_n (cs_s),
    .o_Rise (cs_rise),
    .o_Fall (cs_fall)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    rdv_d     = rdv_q;
    req_d     = req_q;
    tmo_d     = tmo_q;
    ok_d      = ok_q;
    terr_d    = terr_q;
    ovf_d     = ovf_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    push      = 1'b0;
    push_byte = IDLE_BYTE;
    st_rd     = 1'b0;

    // ack beats a timeout landing in the same cycle
    fire = req_q && !i_Bus_Ack && (tmo_q == TMO_LAST);
    done = i_Bus_Ack || fire;

    if (req_q) begin
      tmo_d = tmo_q + 1'b1;
      if (done) begin
        req_d = 1'b0;
        tmo_d = '0;
      end
    end

    // results only count while the frame still wants them
    if (req_q && i_Bus_Ack &&
        (state_q == S_BUS || state_q == S_TURN)) begin
      ok_d = 1'b1;
      if (state_q == S_TURN) begin
        rd_d  = i_Bus_RData;
        rdv_d = 1'b1;
      end
    end
    if (fire && state_q != S_ABORT) begin
      terr_d = 1'b1;
      ok_d   = 1'b0;
    end

    if (cs_fall) cnt_d = '0;
    if (cs_rise) rdv_d = 1'b0;

    if (cs_s) begin
      state_d = (req_q && !done) ? S_ABORT : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (i_RX_DV) begin
          cnt_d = '0;
          unique case (1'b1)
            (i_RX_Byte == OP_WRITE): begin
              we_d    = 1'b1;
              state_d = S_ADDR;
            end
            (i_RX_Byte == OP_READ): begin
              we_d    = 1'b0;
              state_d = S_ADDR;
            end
            (i_RX_Byte == OP_STATUS): begin
              push      = 1'b1;
              push_byte = o_Status;
              st_rd     = 1'b1;
              state_d   = S_DRAIN;
            end
            default: state_d = S_DRAIN;
          endcase
        end
        S_ADDR: if (i_RX_DV) begin
          addr_d = (addr_q << 8) | ADDR_W'(i_RX_Byte);
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == 8'(ADDR_B - 1)) begin
            cnt_d = '0;
            if (we_q) begin
              state_d = S_WDATA;
            end else begin
              req_d   = 1'b1;
              tmo_d   = '0;
              rdv_d   = 1'b0;
              state_d = S_TURN;
            end
          end
        end
        S_WDATA: if (i_RX_DV) begin
          wdata_d = (wdata_q << 8) | DATA_W'(i_RX_Byte);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 8'(DATA_B - 1)) begin
            cnt_d   = '0;
            req_d   = 1'b1;
            tmo_d   = '0;
            state_d = S_BUS;
          end
        end
        S_BUS: if (done) state_d = S_DRAIN;
        S_TURN: if (i_RX_DV) begin
          push = 1'b1;
          if (rdv_q) begin
            push_byte = rd_q[DATA_W-1 -: 8];
            rd_d      = (rd_q << 8) | DATA_W'(IDLE_BYTE);
            state_d   = S_RDATA;
          end else begin
            push_byte = NOT_READY;
            terr_d    = 1'b1;
            state_d   = S_DRAIN;
          end
        end
        S_RDATA: if (i_RX_DV) begin
          push      = 1'b1;
          push_byte = rd_q[DATA_W-1 -: 8];
          rd_d      = (rd_q << 8) | DATA_W'(IDLE_BYTE);
        end
        S_ABORT: if (!req_q || done) state_d = S_IDLE;
        default: ;
      endcase
    end

    // a loaded-but-unsent slave byte must not be overwritten
    if (push) begin
      if (i_TX_Ready) begin
        ovf_d = 1'b1;
      end else begin
        tx_dv_d   = 1'b1;
        tx_byte_d = push_byte;
        if (st_rd) begin
          ovf_d  = 1'b0;
          terr_d = 1'b0;
        end
      end
    end

    if (i_RX_DV && (state_q == S_BUS || state_q == S_ABORT))
      ovf_d = 1'b1;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      rdv_q     <= 1'b0;
      req_q     <= 1'b0;
      tmo_q     <= '0;
      ok_q      <= 1'b0;
      terr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= IDLE_BYTE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      rdv_q     <= rdv_d;
      req_q     <= req_d;
      tmo_q     <= tmo_d;
      ok_q      <= ok_d;
      terr_q    <= terr_d;
      ovf_q     <= ovf_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Bus_Req   = req_q;
  assign o_Bus_We    = we_q;
  assign o_Bus_Addr  = addr_q;
  assign o_Bus_WData = wdata_q;

  always_comb begin
    o_Status         = 8'h00;
    o_Status[ST_OK]  = ok_q;
    o_Status[ST_TMO] = terr_q;
    o_Status[ST_OVF] = ovf_q;
  end

endmodule
